// File: rtl/ray_scanner_if.sv
// Handshake and result bus between the board register / move logic and the ray scanner.
interface ray_scanner_if #(
    parameter int BOARD_DIM = 8,
    parameter int PIECE_W   = 4
);
    localparam int POS_W  = $clog2(BOARD_DIM * BOARD_DIM);
    localparam int DIST_W = $clog2(BOARD_DIM);

    logic                                   start;
    logic                                   mode;
    logic [2:0]                             direction;
    logic [POS_W-1:0]                       currentPosition;
    logic [BOARD_DIM*BOARD_DIM*PIECE_W-1:0] bigBoard;
    logic                                   busy;
    logic                                   done;
    logic                                   found;
    logic [POS_W-1:0]                       nearestPosition;
    logic [PIECE_W-1:0]                     nearestPiece;
    logic [DIST_W-1:0]                      distance;

    modport master (
        output start, mode, direction, currentPosition, bigBoard,
        input  busy, done, found, nearestPosition, nearestPiece, distance
    );

    modport slave (
        input  start, mode, direction, currentPosition, bigBoard,
        output busy, done, found, nearestPosition, nearestPiece, distance
    );
endinterface

// File: rtl/ray_scanner.sv
// Sequential line-of-sight scanner: walks one square per clock from an origin
// in a ray or knight direction and reports the nearest occupied square.
module ray_scanner #(
    parameter int BOARD_DIM = 8,
    parameter int PIECE_W   = 4,
    parameter int POS_W     = $clog2(BOARD_DIM * BOARD_DIM),
    parameter int DIST_W    = $clog2(BOARD_DIM)
) (
    input  logic         clk,
    input  logic         reset,
    ray_scanner_if.slave bus
);
    localparam int NSQ  = BOARD_DIM * BOARD_DIM;
    localparam int RC_W = DIST_W + 2;
    localparam logic signed [RC_W-1:0] DIM_S = RC_W'(BOARD_DIM);

    typedef enum logic [1:0] {IDLE, STEP, FINISH} state_t;

    state_t                   state;
    logic                     mode_q;
    logic [2:0]               dir_q;
    logic [DIST_W-1:0]        row_q;
    logic [DIST_W-1:0]        col_q;
    logic [DIST_W-1:0]        count_q;
    logic [PIECE_W-1:0]       board_q [NSQ];

    logic signed [2:0]        d_row;
    logic signed [2:0]        d_col;
    logic signed [RC_W-1:0]   cand_row;
    logic signed [RC_W-1:0]   cand_col;
    logic                     on_board;
    logic [POS_W-1:0]         cur_idx;
    logic [POS_W-1:0]         cand_idx;
    logic [PIECE_W-1:0]       cand_piece;
    logic                     accept;

    assign accept = bus.start && (state != STEP);

    // Decode the latched direction into a (row, col) step for the latched mode
    always_comb begin
        d_row = '0;
        d_col = '0;
        if (mode_q) begin
            case (dir_q)
                3'd0: begin d_row = -3'sd1; d_col = -3'sd2; end
                3'd1: begin d_row = -3'sd2; d_col = -3'sd1; end
                3'd2: begin d_row = -3'sd2; d_col =  3'sd1; end
                3'd3: begin d_row = -3'sd1; d_col =  3'sd2; end
                3'd4: begin d_row =  3'sd1; d_col =  3'sd2; end
                3'd5: begin d_row =  3'sd2; d_col =  3'sd1; end
                3'd6: begin d_row =  3'sd2; d_col = -3'sd1; end
                default: begin d_row = 3'sd1; d_col = -3'sd2; end
            endcase
        end else begin
            case (dir_q)
                3'd0: begin d_row = -3'sd1; d_col =  3'sd0; end
                3'd1: begin d_row = -3'sd1; d_col =  3'sd1; end
                3'd2: begin d_row =  3'sd0; d_col =  3'sd1; end
                3'd3: begin d_row =  3'sd1; d_col =  3'sd1; end
                3'd4: begin d_row =  3'sd1; d_col =  3'sd0; end
                3'd5: begin d_row =  3'sd1; d_col = -3'sd1; end
                3'd6: begin d_row =  3'sd0; d_col = -3'sd1; end
                default: begin d_row = -3'sd1; d_col = -3'sd1; end
            endcase
        end
    end

    // Candidate square with independent row/col bounds so an edge never wraps to the next row
    always_comb begin
        cand_row   = $signed({2'b00, row_q}) + RC_W'(d_row);
        cand_col   = $signed({2'b00, col_q}) + RC_W'(d_col);
        on_board   = !cand_row[RC_W-1] && (cand_row < DIM_S) &&
                     !cand_col[RC_W-1] && (cand_col < DIM_S);
        cur_idx    = POS_W'(row_q) * POS_W'(BOARD_DIM) + POS_W'(col_q);
        cand_idx   = '0;
        if (on_board) begin
            cand_idx = POS_W'(cand_row[DIST_W-1:0]) * POS_W'(BOARD_DIM) +
                       POS_W'(cand_col[DIST_W-1:0]);
        end
        cand_piece = board_q[cand_idx];
    end

    // Snapshot of the board taken when a scan is accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned s = 0; s < NSQ; s++) begin
                board_q[s] <= bus.bigBoard[s*PIECE_W +: PIECE_W];
            end
        end
    end

    // Scan control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            mode_q              <= 1'b0;
            dir_q               <= '0;
            row_q               <= '0;
            col_q               <= '0;
            count_q             <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.found           <= 1'b0;
            bus.nearestPosition <= '0;
            bus.nearestPiece    <= '0;
            bus.distance        <= '0;
        end else begin
            case (state)
                STEP: begin
                    if (!on_board) begin
                        bus.found           <= 1'b0;
                        bus.nearestPosition <= cur_idx;
                        bus.nearestPiece    <= '0;
                        bus.distance        <= count_q;
                        bus.busy            <= 1'b0;
                        bus.done            <= 1'b1;
                        state               <= FINISH;
                    end else if (cand_piece != '0) begin
                        bus.found           <= 1'b1;
                        bus.nearestPosition <= cand_idx;
                        bus.nearestPiece    <= cand_piece;
                        bus.distance        <= count_q + 1'b1;
                        bus.busy            <= 1'b0;
                        bus.done            <= 1'b1;
                        state               <= FINISH;
                    end else if (mode_q) begin
                        bus.found           <= 1'b0;
                        bus.nearestPosition <= cand_idx;
                        bus.nearestPiece    <= '0;
                        bus.distance        <= DIST_W'(1);
                        bus.busy            <= 1'b0;
                        bus.done            <= 1'b1;
                        state               <= FINISH;
                    end else begin
                        row_q   <= cand_row[DIST_W-1:0];
                        col_q   <= cand_col[DIST_W-1:0];
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and FINISH both accept a new request
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        dir_q    <= bus.direction;
                        row_q    <= DIST_W'(bus.currentPosition / POS_W'(BOARD_DIM));
                        col_q    <= DIST_W'(bus.currentPosition % POS_W'(BOARD_DIM));
                        count_q  <= '0;
                        bus.busy <= 1'b1;
                        state    <= STEP;
                    end else begin
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ray_scanner.sv
// Randomized self-checking bench for ray_scanner against a square-walking reference model.
module tb_ray_scanner;
    localparam int D      = 8;
    localparam int PW     = 4;
    localparam int NSQ    = D * D;
    localparam int POS_W  = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ray_scanner_if #(.BOARD_DIM(D), .PIECE_W(PW)) bus ();

    ray_scanner #(.BOARD_DIM(D), .PIECE_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0] brd [NSQ];

    int ray_dr [8] = '{-1, -1,  0,  1,  1,  1,  0, -1};
    int ray_dc [8] = '{ 0,  1,  1,  1,  0, -1, -1, -1};
    int kn_dr  [8] = '{-1, -2, -2, -1,  1,  2,  2,  1};
    int kn_dc  [8] = '{-2, -1,  1,  2,  2,  1, -1, -2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NSQ*PW-1:0] pack_board();
        logic [NSQ*PW-1:0] v;
        for (int s = 0; s < NSQ; s++) v[s*PW +: PW] = brd[s];
        return v;
    endfunction

    function automatic logic [NSQ*PW-1:0] rand_board();
        logic [NSQ*PW-1:0] v;
        for (int s = 0; s < NSQ; s++) v[s*PW +: PW] = PW'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic clear_board();
        for (int s = 0; s < NSQ; s++) brd[s] = '0;
    endtask

    // Walk the board square by square; steps = number of squares examined
    function automatic void model(input int pos, input int md, input int dir,
                                  output int f, output int np, output int pc,
                                  output int d, output int steps);
        int r, c, nr, nc, dr, dc, cnt;
        r = pos / D;
        c = pos % D;
        cnt = 0;
        steps = 0;
        f = 0; np = pos; pc = 0; d = 0;
        dr = (md != 0) ? kn_dr[dir] : ray_dr[dir];
        dc = (md != 0) ? kn_dc[dir] : ray_dc[dir];
        for (int i = 0; i <= D; i++) begin
            steps++;
            nr = r + dr;
            nc = c + dc;
            if (nr < 0 || nr >= D || nc < 0 || nc >= D) begin
                np = r * D + c; d = cnt;
                return;
            end
            if (brd[nr*D+nc] != 0) begin
                f = 1; np = nr * D + nc; pc = int'(brd[nr*D+nc]); d = cnt + 1;
                return;
            end
            if (md != 0) begin
                np = nr * D + nc; d = 1;
                return;
            end
            r = nr;
            c = nc;
            cnt++;
        end
    endfunction

    task automatic drive(input int pos, input int md, input int dir);
        bus.mode            = md[0];
        bus.direction       = dir[2:0];
        bus.currentPosition = pos[POS_W-1:0];
        bus.bigBoard        = pack_board();
    endtask

    task automatic scan(input int pos, input int md, input int dir, input bit disturb, input string tag);
        int f, np, pc, d, steps, lat;
        bit got;
        model(pos, md, dir, f, np, pc, d, steps);
        @(negedge clk);
        drive(pos, md, dir);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= D + 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (disturb && k > 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin got = 1'b1; lat = k; break; end
            check({tag, "/busy"}, 32'(bus.busy), 32'd1);
            if (disturb && k == 1) begin
                bus.start    = 1'b1;
                bus.bigBoard = rand_board();
            end
        end
        check({tag, "/latency"}, got ? lat : 0, steps + 1);
        check({tag, "/busy_fin"}, 32'(bus.busy), 32'd0);
        check({tag, "/found"}, 32'(bus.found), f);
        check({tag, "/pos"}, 32'(bus.nearestPosition), np);
        check({tag, "/piece"}, 32'(bus.nearestPiece), pc);
        check({tag, "/dist"}, 32'(bus.distance), d);
        @(posedge clk); #1;
        check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "/hold"}, 32'(bus.nearestPosition), np);
    endtask

    // Start held high across FINISH: second request accepted on the FINISH edge
    task automatic back_to_back(input int pa, input int da, input int pb, input int db);
        int fa, npa, pca, dA, sa, fb, npb, pcb, dB, sb, lat;
        bit got;
        model(pa, 0, da, fa, npa, pca, dA, sa);
        model(pb, 1, db, fb, npb, pcb, dB, sb);
        @(negedge clk);
        drive(pa, 0, da);
        bus.start = 1'b1;
        @(posedge clk); #1;
        got = 1'b0; lat = 0;
        for (int k = 1; k <= D + 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (bus.done === 1'b1) begin got = 1'b1; lat = k; break; end
        end
        check("b2b_a/latency", got ? lat : 0, sa + 1);
        check("b2b_a/pos", 32'(bus.nearestPosition), npa);
        drive(pb, 1, db);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_b/busy", 32'(bus.busy), 32'd1);
        got = 1'b0; lat = 0;
        for (int k = 1; k <= D + 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (bus.done === 1'b1) begin got = 1'b1; lat = k; break; end
        end
        check("b2b_b/latency", got ? lat : 0, sb + 1);
        check("b2b_b/found", 32'(bus.found), fb);
        check("b2b_b/pos", 32'(bus.nearestPosition), npb);
        check("b2b_b/dist", 32'(bus.distance), dB);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_scan();
        int dones;
        clear_board();
        @(negedge clk);
        drive(0, 0, 2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst/busy", 32'(bus.busy), 32'd0);
        check("rst/done", 32'(bus.done), 32'd0);
        check("rst/found", 32'(bus.found), 32'd0);
        check("rst/pos", 32'(bus.nearestPosition), 32'd0);
        check("rst/piece", 32'(bus.nearestPiece), 32'd0);
        check("rst/dist", 32'(bus.distance), 32'd0);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) dones++;
        end
        check("rst/no_done", dones, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        clear_board();
        drive(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", 32'(bus.busy), 32'd0);
        check("reset/done", 32'(bus.done), 32'd0);
        check("reset/found", 32'(bus.found), 32'd0);
        check("reset/pos", 32'(bus.nearestPosition), 32'd0);
        check("reset/piece", 32'(bus.nearestPiece), 32'd0);
        check("reset/dist", 32'(bus.distance), 32'd0);
        reset = 1'b0;

        clear_board();
        scan(27, 0, 2, 1'b0, "empty_east");
        brd[11] = 4'hA;
        scan(27, 0, 0, 1'b0, "hit_north");
        clear_board();
        scan(63, 0, 4, 1'b0, "edge_south");
        scan(0, 1, 0, 1'b0, "knight_off");
        brd[44] = 4'h3;
        scan(27, 1, 5, 1'b0, "knight_hit");
        clear_board();
        brd[25] = 4'h5;
        scan(27, 0, 6, 1'b1, "disturb_west");
        clear_board();
        brd[3] = 4'h7;
        scan(59, 0, 0, 1'b1, "disturb_long");

        reset_mid_scan();
        clear_board();
        brd[36] = 4'h9;
        scan(0, 0, 3, 1'b0, "after_rst");

        clear_board();
        brd[30] = 4'h2;
        back_to_back(24, 2, 20, 6);

        for (int t = 0; t < 150; t++) begin
            int thr;
            thr = $urandom_range(0, 4);
            for (int s = 0; s < NSQ; s++)
                brd[s] = ($urandom_range(0, 7) < thr) ? PW'($urandom_range(1, 15)) : '0;
            scan($urandom_range(0, NSQ - 1), $urandom_range(0, 1), $urandom_range(0, 7),
                 (t % 5) == 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
